restador_serie: RTL and testbench

- Parametrised, digit-serial add/subtract unit; the sequential successor of the 4-bit combinational restador.
- Processes DIGIT bits per clock, LSB first. Takes WIDTH/DIGIT cycles per operation.
- Uses valid/ready handshakes on input and output, so it can sit between pipeline stages of the datapath.
- Outputs the result plus unsigned borrow/carry, signed overflow and zero flags.

---
 rtl/restador_serie_pkg.sv | 17 +
 rtl/restador_digito.sv | 22 ++
 rtl/restador_serie.sv | 107 ++++++++++
 tb/tb_restador_serie.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/restador_serie_pkg.sv
// Shared constants for the digit-serial add/subtract unit: FSM encoding,
// mode encoding and a counter sizing helper.
package restador_serie_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic MODO_SUB = 1'b0;
  localparam logic MODO_ADD = 1'b1;

  // Digit counter must be at least one bit wide, even for a single digit.
  function automatic int cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/restador_digito.sv
// One DIGIT-bit slice of the ripple adder: sum, carry out, and the carry
// entering the slice's top bit (needed for signed overflow).
module restador_digito #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] sum;

  assign sum  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign s    = sum[DIGIT-1:0];
  assign cout = sum[DIGIT];
  // A full adder's sum bit is x^y^cin, so the top-bit carry-in falls out of it.
  assign c_msb_in = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/restador_serie.sv
// Digit-serial add/subtract unit, LSB first, DIGIT bits per cycle, with
// valid/ready handshakes and borrow/carry, overflow and zero flags.
module restador_serie
  import restador_serie_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             modo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             carri_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("restador_serie: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             modo_r;
  logic             carry_r;

  logic [DIGIT-1:0] s;
  logic             cout;
  logic             c_msb_in;
  logic [WIDTH-1:0] s_ext;
  logic [WIDTH-1:0] diff_nxt;

  restador_digito #(.DIGIT(DIGIT)) u_digito (
    .x        (op_a[DIGIT-1:0]),
    .y        (op_b[DIGIT-1:0]),
    .cin      (carry_r),
    .s        (s),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  // Result shifts in from the top so that after NDIG slices it is aligned.
  always_comb begin
    s_ext = '0;
    s_ext[DIGIT-1:0] = s;
    diff_nxt = (diff >> DIGIT) | (s_ext << (WIDTH - DIGIT));
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      carry_r   <= 1'b0;
      diff      <= '0;
      carri_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a    <= a;
            op_b    <= b ^ {WIDTH{modo == MODO_SUB}};
            modo_r  <= modo;
            carry_r <= (modo == MODO_SUB);
            cnt     <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          op_a    <= op_a >> DIGIT;
          op_b    <= op_b >> DIGIT;
          carry_r <= cout;
          diff    <= diff_nxt;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= S_DONE;
            cnt       <= '0;
            carri_out <= (modo_r == MODO_ADD) ? cout : ~cout;
            overflow  <= c_msb_in ^ cout;
            zero      <= (diff_nxt == '0);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restador_serie.sv
// Bench for restador_serie: three instances (4/1, 4/2, 8/4) checked against
// an arithmetic reference model, with directed, backpressure and reset cases.
module tb_restador_serie;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]      iv, ordy, md;
  logic [2:0][7:0] av, bv;
  wire  [2:0]      ir, ovl, co, of, zf;
  wire  [3:0]      d0, d1;
  wire  [7:0]      d2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  restador_serie #(.WIDTH(4), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][3:0]), .b(bv[0][3:0]), .modo(md[0]),
    .out_valid(ovl[0]), .out_ready(ordy[0]), .diff(d0),
    .carri_out(co[0]), .overflow(of[0]), .zero(zf[0]));

  restador_serie #(.WIDTH(4), .DIGIT(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][3:0]), .b(bv[1][3:0]), .modo(md[1]),
    .out_valid(ovl[1]), .out_ready(ordy[1]), .diff(d1),
    .carri_out(co[1]), .overflow(of[1]), .zero(zf[1]));

  restador_serie #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]), .modo(md[2]),
    .out_valid(ovl[2]), .out_ready(ordy[2]), .diff(d2),
    .carri_out(co[2]), .overflow(of[2]), .zero(zf[2]));

  function automatic int get_diff(input int u);
    case (u)
      0:       return int'(d0);
      1:       return int'(d1);
      default: return int'(d2);
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int w, input int a, input int b, input bit m,
                       output int d, output bit c, output bit o, output bit z);
    int mask, half, sa, sb, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    d  = (m ? a + b : a - b) & mask;
    c  = m ? ((a + b) > mask) : (a < b);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    sr = m ? sa + sb : sa - sb;
    o  = (sr >= half) || (sr < -half);
    z  = (d == 0);
  endtask

  task automatic wait_out(input int u, output int lat);
    lat = 0;
    while (!ovl[u] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake(input int u, input string tag);
    ordy[u] = 1'b1;
    @(posedge clk); #1;
    ordy[u] = 1'b0;
    chk({tag, " out_valid after handshake"}, int'(ovl[u]), 0);
    chk({tag, " in_ready after handshake"}, int'(ir[u]), 1);
  endtask

  task automatic run_chk(input int u, input int w, input int ndig,
                         input int a, input int b, input bit m);
    int lat, ed;
    bit ec, eo, ez;
    string tag;
    tag = $sformatf("u%0d %0d%s%0d", u, a, m ? "+" : "-", b);
    model(w, a, b, m, ed, ec, eo, ez);
    @(negedge clk);
    chk({tag, " in_ready"}, int'(ir[u]), 1);
    av[u] = 8'(a); bv[u] = 8'(b); md[u] = m; iv[u] = 1'b1;
    @(posedge clk); #1;
    iv[u] = 1'b0;
    av[u] = 8'($urandom); bv[u] = 8'($urandom); md[u] = 1'($urandom);
    wait_out(u, lat);
    chk({tag, " latency"}, lat, ndig);
    chk({tag, " diff"}, get_diff(u), ed);
    chk({tag, " carri_out"}, int'(co[u]), int'(ec));
    chk({tag, " overflow"}, int'(of[u]), int'(eo));
    chk({tag, " zero"}, int'(zf[u]), int'(ez));
    handshake(u, tag);
  endtask

  initial begin
    int lat;
    rst = 1'b1; iv = '0; ordy = '0; md = '0; av = '0; bv = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", int'(ir), 7);
    chk("reset out_valid", int'(ovl), 0);
    chk("reset flags", int'({co, of, zf}), 0);
    chk("reset diff", int'({d0, d1, d2}), 0);

    // Directed cases
    run_chk(0, 4, 4, 5, 3, 1'b0);
    run_chk(0, 4, 4, 3, 5, 1'b0);
    run_chk(0, 4, 4, 7, 8, 1'b0);
    chk("u0 7-8 diff const", int'(d0), 15);
    run_chk(1, 4, 2, 9, 8, 1'b1);
    chk("u1 9+8 diff const", int'(d1), 1);
    run_chk(1, 4, 2, 6, 6, 1'b0);
    chk("u1 6-6 zero const", int'(zf[1]), 1);
    run_chk(0, 4, 4, 0, 1, 1'b0);

    // Backpressure: new operands offered while the result is held
    @(negedge clk);
    av[0] = 8'd5; bv[0] = 8'd3; md[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    av[0] = 8'd2; bv[0] = 8'd1;
    wait_out(0, lat);
    chk("bp latency", lat, 4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp held diff", int'(d0), 2);
      chk("bp held flags", int'({co[0], of[0], zf[0]}), 0);
      chk("bp in_ready", int'(ir[0]), 0);
      chk("bp out_valid", int'(ovl[0]), 1);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("bp idle out_valid", int'(ovl[0]), 0);
    chk("bp idle in_ready", int'(ir[0]), 1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("bp accepted", int'(ir[0]), 0);
    wait_out(0, lat);
    chk("bp second latency", lat, 4);
    chk("bp second diff", int'(d0), 1);
    handshake(0, "bp second");

    // Reset in the second CALC cycle
    @(negedge clk);
    av[0] = 8'd7; bv[0] = 8'd1; md[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst mid out_valid", int'(ovl[0]), 0);
    chk("rst mid in_ready", int'(ir[0]), 1);
    chk("rst mid diff", int'(d0), 0);
    run_chk(0, 4, 4, 4, 1, 1'b0);
    chk("rst follow diff const", int'(d0), 3);

    // Random small-width ops
    for (int i = 0; i < 40; i++) begin
      run_chk(0, 4, 4, int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom));
      run_chk(1, 4, 2, int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom));
    end

    // 8-bit corners, then random sweep
    for (int m = 0; m < 2; m++) begin
      run_chk(2, 8, 2, 0, 0, 1'(m));
      run_chk(2, 8, 2, 0, 1, 1'(m));
      run_chk(2, 8, 2, 255, 255, 1'(m));
      run_chk(2, 8, 2, 128, 1, 1'(m));
      run_chk(2, 8, 2, 127, 128, 1'(m));
      run_chk(2, 8, 2, 127, 1, 1'(m));
      run_chk(2, 8, 2, 128, 128, 1'(m));
    end
    for (int i = 0; i < 1500; i++) begin
      run_chk(2, 8, 2, int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
